// File: rtl/rr_mux_reg_pkg.sv
// Shared constants and helpers for the round-robin arbitrating output register.
package rr_mux_reg_pkg;

   // Default geometry of the multiplexer.
   localparam int RR_DEFAULT_WIDTH = 32;
   localparam int RR_DEFAULT_NCH   = 4;

   // Arbitration mode encodings used for the MODE parameter.
   localparam int RR_MODE_ROUND_ROBIN = 0;
   localparam int RR_MODE_FIXED       = 1;

   // Mode as seen by the priority picker.
   typedef enum logic {
      PICK_RR    = 1'b0,
      PICK_FIXED = 1'b1
   } pick_mode_e;

   // Pointer value after channel g wins: the search restarts just past the winner.
   function automatic int rr_next_ptr(input int g, input int nch);
      return (g == nch - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_mux_reg_priority_pick.sv
// Combinational priority picker: finds the first requesting channel, searching
// upward from ptr (round-robin) or from index 0 (fixed priority), with wrap-around.
module rr_priority_pick
   import rr_mux_reg_pkg::*;
#(
   parameter int NCH  = RR_DEFAULT_NCH,
   parameter int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  pick_mode_e      mode,
   output logic [NCH-1:0]  gnt_onehot,
   output logic [SELW-1:0] gnt_idx,
   output logic            any
);

   int              base;
   int              idx;
   logic [SELW-1:0] idx_s;

   // Scan channels in priority order and keep only the first requester.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      idx        = 0;
      idx_s      = '0;
      base       = (mode == PICK_FIXED) ? 0 : int'(ptr);
      for (int k = 0; k < NCH; k++) begin
         idx = base + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         idx_s = idx[SELW-1:0];
         if (!any && req[idx_s]) begin
            any               = 1'b1;
            gnt_onehot[idx_s] = 1'b1;
            gnt_idx           = idx_s;
         end
      end
   end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel arbitrating multiplexer feeding a one-entry registered output stage.
// One channel is accepted per cycle whenever the output register is empty or
// being drained, giving one word per cycle with no bubble.
module rr_mux_reg
   import rr_mux_reg_pkg::*;
#(
   parameter  int WIDTH = RR_DEFAULT_WIDTH,
   parameter  int NCH   = RR_DEFAULT_NCH,
   parameter  int MODE  = RR_MODE_ROUND_ROBIN,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam pick_mode_e PICK_MODE = (MODE == RR_MODE_FIXED) ? PICK_FIXED : PICK_RR;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_sel_q,   out_sel_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic [NCH-1:0]   gnt_onehot;
   logic [SELW-1:0]  gnt_idx;
   logic             gnt_any;
   logic             can_load;
   logic             load;
   logic [WIDTH-1:0] sel_word;

   rr_priority_pick #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_pick (
      .req        (in_valid),
      .ptr        (ptr_q),
      .mode       (PICK_MODE),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   // Handshake: the register can take a word when empty or being emptied this cycle.
   // in_ready is forced low while reset is held so nothing looks accepted.
   always_comb begin
      can_load = ~out_valid_q | out_ready;
      load     = gnt_any & can_load;
      in_ready = gnt_onehot & {NCH{can_load & rst_n}};
   end

   // Route the granted channel's word toward the output register.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_onehot[i]) begin
            sel_word = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next state: load replaces the held word; a drain with no load only clears valid.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_word;
         out_sel_d   = gnt_idx;
         if (MODE == RR_MODE_ROUND_ROBIN) begin
            ptr_d = SELW'(rr_next_ptr(int'(gnt_idx), NCH));
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register and round-robin pointer; reset drops any held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: round-robin, fixed-priority and 2-channel instances.
module tb_rr_mux_reg;
   import rr_mux_reg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Round-robin, 4 x 32
   logic [127:0] rr_data;
   logic [3:0]   rr_vld, rr_rdy;
   logic         rr_ordy, rr_ov;
   logic [31:0]  rr_odata;
   logic [1:0]   rr_osel;

   // Fixed priority, 4 x 32
   logic [127:0] fp_data;
   logic [3:0]   fp_vld, fp_rdy;
   logic         fp_ordy, fp_ov;
   logic [31:0]  fp_odata;
   logic [1:0]   fp_osel;

   // Round-robin, 2 x 8
   logic [15:0]  n2_data;
   logic [1:0]   n2_vld, n2_rdy;
   logic         n2_ordy, n2_ov;
   logic [7:0]   n2_odata;
   logic [0:0]   n2_osel;

   rr_mux_reg #(.WIDTH(32), .NCH(4), .MODE(RR_MODE_ROUND_ROBIN)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(rr_data), .in_valid(rr_vld), .in_ready(rr_rdy),
      .out_data(rr_odata), .out_sel(rr_osel), .out_valid(rr_ov), .out_ready(rr_ordy));

   rr_mux_reg #(.WIDTH(32), .NCH(4), .MODE(RR_MODE_FIXED)) u_fp (
      .clk(clk), .rst_n(rst_n), .in_data(fp_data), .in_valid(fp_vld), .in_ready(fp_rdy),
      .out_data(fp_odata), .out_sel(fp_osel), .out_valid(fp_ov), .out_ready(fp_ordy));

   rr_mux_reg #(.WIDTH(8), .NCH(2), .MODE(RR_MODE_ROUND_ROBIN)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_data(n2_data), .in_valid(n2_vld), .in_ready(n2_rdy),
      .out_data(n2_odata), .out_sel(n2_osel), .out_valid(n2_ov), .out_ready(n2_ordy));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   localparam logic [31:0] D0 = 32'h1000_0000;
   localparam logic [31:0] D1 = 32'h1000_0001;
   localparam logic [31:0] D2 = 32'h1000_0002;
   localparam logic [31:0] D3 = 32'h1000_0003;

   initial begin
      // Fairness, backpressure, wrap, drain and stall on the round-robin instance.
      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[5]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[13] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[14] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1};
      vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, D1};
      vecs[17] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, D1};
      vecs[18] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1};

      rst_n   = 1'b0;
      rr_vld  = '0;  rr_ordy = 1'b0;
      fp_vld  = '0;  fp_ordy = 1'b0;
      n2_vld  = '0;  n2_ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rr_data[i*32 +: 32] = 32'h1000_0000 + i;
         fp_data[i*32 +: 32] = 32'h1000_0000 + i;
      end
      n2_data = {8'hB1, 8'hA0};

      #3;
      chk("reset_out", {29'd0, rr_ov, rr_osel, rr_odata}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Table-driven section.
      for (int i = 0; i < NVEC; i++) begin
         rr_vld  = vecs[i].vld;
         rr_ordy = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", i), {60'd0, rr_rdy}, {60'd0, vecs[i].exp_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out", i), {29'd0, rr_ov, rr_osel, rr_odata},
             {29'd0, vecs[i].exp_ov, vecs[i].exp_sel, vecs[i].exp_data});
      end

      // Single channel word with one-cycle latency.
      rr_data[32 +: 32] = 32'hA5A5_0001;
      rr_vld  = 4'b0010;
      rr_ordy = 1'b1;
      #1 chk("single_in_ready", {60'd0, rr_rdy}, {60'd0, 4'b0010});
      @(posedge clk);
      #1 chk("single_out", {29'd0, rr_ov, rr_osel, rr_odata}, {29'd0, 1'b1, 2'd1, 32'hA5A5_0001});

      // Asynchronous reset while a word is held and the output is stalled.
      rr_vld  = 4'b0100;
      rr_ordy = 1'b0;
      #1 chk("stall_in_ready", {60'd0, rr_rdy}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", {29'd0, rr_ov, rr_osel, rr_odata}, 64'd0);
      chk("async_reset_in_ready", {60'd0, rr_rdy}, 64'd0);
      @(posedge clk);
      #1 chk("held_reset_in_ready", {60'd0, rr_rdy}, 64'd0);
      rst_n = 1'b1;
      #1 chk("post_reset_in_ready", {60'd0, rr_rdy}, {60'd0, 4'b0100});
      rr_vld  = 4'b1111;
      rr_ordy = 1'b1;
      #1 chk("post_reset_ptr_zero", {60'd0, rr_rdy}, {60'd0, 4'b0001});
      @(posedge clk);
      #1 chk("post_reset_out", {29'd0, rr_ov, rr_osel, rr_odata}, {29'd0, 1'b1, 2'd0, D0});
      rr_vld = '0;

      // Fixed priority: ch1 starves ch3 until it drops.
      fp_ordy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fp_vld = 4'b1010;
         #1 chk($sformatf("fp%0d_in_ready", k), {60'd0, fp_rdy}, {60'd0, 4'b0010});
         @(posedge clk);
         #1 chk($sformatf("fp%0d_out", k), {29'd0, fp_ov, fp_osel, fp_odata}, {29'd0, 1'b1, 2'd1, D1});
      end
      fp_vld = 4'b1000;
      #1 chk("fp_ch3_in_ready", {60'd0, fp_rdy}, {60'd0, 4'b1000});
      @(posedge clk);
      #1 chk("fp_ch3_out", {29'd0, fp_ov, fp_osel, fp_odata}, {29'd0, 1'b1, 2'd3, D3});
      fp_vld = '0;

      // Two channels, 8 bits: grants alternate 0,1,0,1.
      n2_vld  = 2'b11;
      n2_ordy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("n2_%0d_in_ready", k), {62'd0, n2_rdy},
                {62'd0, (k % 2 == 0) ? 2'b01 : 2'b10});
         @(posedge clk);
         #1 chk($sformatf("n2_%0d_out", k), {55'd0, n2_ov, n2_osel, n2_odata},
                {55'd0, 1'b1, (k % 2 == 0) ? 1'b0 : 1'b1, (k % 2 == 0) ? 8'hA0 : 8'hB1});
      end
      n2_vld = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
